// File: rtl/sram_port_arbiter_if.sv
// Bundle of requester-side handshakes (ports A and B) and the SRAM macro pins
// that the arbiter sits between.
interface sram_port_arbiter_if #(
  parameter int W_DATA = 32,
  parameter int W_ADDR = 11
);
  localparam int W_BE = W_DATA / 8;

  // Port A: high-priority read-only streaming
  logic              a_req;
  logic [W_ADDR-1:0] a_addr;
  logic              a_ready;
  logic              a_rvalid;
  logic [W_DATA-1:0] a_rdata;

  // Port B: low-priority read/write
  logic              b_req;
  logic              b_write;
  logic [W_ADDR-1:0] b_addr;
  logic [W_DATA-1:0] b_wdata;
  logic [W_BE-1:0]   b_be;
  logic              b_ready;
  logic              b_rvalid;
  logic [W_DATA-1:0] b_rdata;

  // SRAM macro pins
  logic              sram_cs_n;
  logic              sram_we_n;
  logic [W_BE-1:0]   sram_be_n;
  logic [W_ADDR-1:0] sram_addr;
  logic [W_DATA-1:0] sram_wdata;
  logic [W_DATA-1:0] sram_rdata;

  modport slave (
    input  a_req, a_addr,
    output a_ready, a_rvalid, a_rdata,
    input  b_req, b_write, b_addr, b_wdata, b_be,
    output b_ready, b_rvalid, b_rdata,
    output sram_cs_n, sram_we_n, sram_be_n, sram_addr, sram_wdata,
    input  sram_rdata
  );

  modport master (
    output a_req, a_addr,
    input  a_ready, a_rvalid, a_rdata,
    output b_req, b_write, b_addr, b_wdata, b_be,
    input  b_ready, b_rvalid, b_rdata,
    input  sram_cs_n, sram_we_n, sram_be_n, sram_addr, sram_wdata,
    output sram_rdata
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// Two-port arbiter for one single-port synchronous SRAM: port A (read stream)
// has priority, port B gets a forced grant after MAX_STALL consecutive denials.
module sram_port_arbiter #(
  parameter int W_DATA    = 32,
  parameter int W_ADDR    = 11,
  parameter int MAX_STALL = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  sram_port_arbiter_if.slave  bus
);
  localparam int W_BE = W_DATA / 8;
  localparam logic [7:0] STALL_LIMIT = 8'(MAX_STALL);

  logic [7:0]        stall_cnt;
  logic              force_b;
  logic              a_grant;
  logic              b_grant;
  logic              b_any_be;
  logic [W_ADDR-1:0] addr_mux;
  logic [W_BE-1:0]   be_n_mux;

  // Grant is purely combinational so a request can be accepted in its first cycle.
  assign force_b  = bus.b_req && (stall_cnt == STALL_LIMIT);
  assign a_grant  = bus.a_req && !force_b;
  assign b_grant  = bus.b_req && !a_grant;
  assign b_any_be = |bus.b_be;

  assign bus.a_ready = a_grant;
  assign bus.b_ready = b_grant;

  // NOTE: every output of an always_comb gets a default first so no path
  // through the block leaves a signal unassigned and infers a latch.
  always_comb begin
    bus.sram_cs_n = 1'b1;
    bus.sram_we_n = 1'b1;
    be_n_mux      = '1;
    addr_mux      = bus.b_addr;
    if (a_grant) begin
      bus.sram_cs_n = 1'b0;
      addr_mux      = bus.a_addr;
    end else if (b_grant) begin
      if (bus.b_write) begin
        // An all-zero byte mask is accepted but leaves the SRAM deselected.
        bus.sram_cs_n = !b_any_be;
        bus.sram_we_n = !b_any_be;
        be_n_mux      = ~bus.b_be;
      end else begin
        bus.sram_cs_n = 1'b0;
      end
    end
  end

  assign bus.sram_addr  = addr_mux;
  assign bus.sram_be_n  = be_n_mux;
  assign bus.sram_wdata = bus.b_wdata;

  // Read data is shared; each port qualifies it with its own rvalid.
  assign bus.a_rdata = bus.sram_rdata;
  assign bus.b_rdata = bus.sram_rdata;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt    <= 8'd0;
      bus.a_rvalid <= 1'b0;
      bus.b_rvalid <= 1'b0;
    end else begin
      bus.a_rvalid <= a_grant;
      bus.b_rvalid <= b_grant && !bus.b_write;
      if (!bus.b_req || b_grant) begin
        stall_cnt <= 8'd0;
      end else if (stall_cnt != STALL_LIMIT) begin
        stall_cnt <= stall_cnt + 8'd1;
      end
    end
  end
endmodule
